rs_station: RTL and testbench
=============================

Name: rs_station

Overview:
- Reservation station at the receiving end of the issue stage's RS dispatch interface, in the Tomasulo RISC-V core.
- Buffers ALU, branch, jump, lui and auipc micro-ops together with their operand tags and values.
- Snoops the ALU and LSB common data buses (CDB) to wake up pending operands.
- Each cycle, sends the oldest-index entry whose operands are both ready to the ALU.

Parameters:
- DEPTH, 16: number of entries; power of two.
- IDX_W, 4: log2(DEPTH).
- TAG_W, 5: ROB number width.
- DATA_W, 32: operand, data and status width.
- OP_W, 6: opcode width; matches the core opcode enumeration.
- READY_TAG, 32'hFFFFFFFF: status value meaning "operand value present", same as the issue stage's MAXN.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global stall; state advances only when 1.
- clear  in  1  branch-mispredict flush.
- issue_en  in  1  issue request (the issue stage's RS_o).
- issue_op  in  OP_W  opcode.
- issue_q1, issue_q2  in  DATA_W  operand status: ROB tag, or READY_TAG.
- issue_v1, issue_v2  in  DATA_W  operand values; valid when the matching q is READY_TAG.
- issue_rob  in  TAG_W  destination ROB number.
- rs_full  out  1  back-pressure to the issue stage.
- alu_cdb_en  in  1  ALU CDB valid.
- alu_cdb_rob  in  TAG_W  ALU CDB ROB number.
- alu_cdb_val  in  DATA_W  ALU CDB value.
- lsb_cdb_en  in  1  LSB CDB valid.
- lsb_cdb_rob  in  TAG_W  LSB CDB ROB number.
- lsb_cdb_val  in  DATA_W  LSB CDB value.
- ex_en  out  1  dispatch valid, one-cycle pulse.
- ex_op  out  OP_W  dispatched opcode.
- ex_v1, ex_v2  out  DATA_W  dispatched operand values.
- ex_rob  out  TAG_W  dispatched ROB number.

Behaviour:
- Entry state: busy, op, q1, v1, q2, v2, rob.
- Tag match rule: a status matches a CDB when status equals the ROB number zero-extended to DATA_W. READY_TAG never matches.
- Reset (rst_in=0, asynchronous): all busy bits = 0; ex_en, ex_op, ex_v1, ex_v2, ex_rob = 0.
- rdy_in=0: all state and registered outputs hold; inputs are ignored.
- clear=1 (with rdy_in=1), at the edge:
  - All busy bits = 0; ex_en = 0.
  - Any issue or CDB input in that same cycle is discarded.
  - clear takes priority over everything except reset.
- rs_full (combinational) = busy count >= DEPTH-1. This reserves one slot for an issue already in flight.
- Issue, at the edge when issue_en=1:
  - Writes into the lowest-index entry that is not busy in the pre-edge state.
  - If no entry is free, the request is dropped and a simulation assertion fires. An existing entry is never overwritten.
- Issue-time bypass: if issue_qX matches a CDB that is valid in the same cycle, the entry stores that CDB value and qX = READY_TAG.
- Wakeup, every edge: each busy entry with qX matching a valid CDB gets vX <= CDB value and qX <= READY_TAG.
  - Both CDBs matching the same tag cannot occur; if it does, ALU wins.
- Dispatch, every edge:
  - Select the lowest-index busy entry whose q1 and q2 both equal READY_TAG, using pre-edge state.
  - Selected: ex_en <= 1, ex_* <= entry fields, entry busy <= 0.
  - None selected: ex_en <= 0; other ex_* outputs hold.
- Latency:
  - Issue with both operands ready at edge N gives ex_en=1 after edge N+1.
  - An operand woken at edge N allows dispatch after edge N+1.
  - Minimum issue-to-execute latency is 1 cycle; there is no combinational issue-to-ex path.
- Simultaneous events:
  - A slot freed by dispatch at edge N can be reused by an issue no earlier than edge N+1.
  - Wakeup and dispatch evaluate the same pre-edge state, so a wakeup never causes dispatch in the same edge.
- Throughput: one dispatch per cycle.

Test Plan:
- Reset release, then issue add (op=add, q1=q2=READY_TAG, v1=5, v2=7, rob=3) -> ex_en=1 with ex_v1=5, ex_v2=7, ex_rob=3 exactly one cycle after issue; ex_en=0 on the following cycle.
- Issue with q1=tag 9 -> held. Pulse alu_cdb_en with rob=9, val=0x100 -> next edge ex_en=1, ex_v1=0x100. A second entry waiting on tag 10, woken by lsb_cdb, likewise gets the LSB value.
- Issue with q2=tag 4 while lsb_cdb_en, rob=4, val=0xABCD in the same cycle -> entry captured ready; dispatched next cycle with ex_v2=0xABCD.
- Fill 15 entries waiting on tag 1 -> rs_full=1 at count 15. Broadcast tag 1 -> entries 0..14 dispatch in index order over 15 consecutive cycles. rs_full drops when count <= 14.
- 8 pending entries, assert clear with a simultaneous issue and CDB -> busy count 0, ex_en=0, no dispatch afterwards. Then a fresh issue dispatches normally.
- Hold rdy_in=0 for 5 cycles with a ready entry -> no dispatch and ex_* stable. Deassert rst_in mid-run -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rs_station_if.sv
// Dispatch-side bus of the reservation station: issue request, CDB snoop inputs
// and the execute port toward the ALU. The issue/CDB side is the master.
interface rs_station_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic              issue_en;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_q1;
    logic [DATA_W-1:0] issue_q2;
    logic [DATA_W-1:0] issue_v1;
    logic [DATA_W-1:0] issue_v2;
    logic [TAG_W-1:0]  issue_rob;
    logic              rs_full;

    logic              alu_cdb_en;
    logic [TAG_W-1:0]  alu_cdb_rob;
    logic [DATA_W-1:0] alu_cdb_val;
    logic              lsb_cdb_en;
    logic [TAG_W-1:0]  lsb_cdb_rob;
    logic [DATA_W-1:0] lsb_cdb_val;

    logic              ex_en;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_v1;
    logic [DATA_W-1:0] ex_v2;
    logic [TAG_W-1:0]  ex_rob;

    modport master (
        output issue_en, issue_op, issue_q1, issue_q2, issue_v1, issue_v2, issue_rob,
        output alu_cdb_en, alu_cdb_rob, alu_cdb_val,
        output lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val,
        input  rs_full, ex_en, ex_op, ex_v1, ex_v2, ex_rob
    );

    modport slave (
        input  issue_en, issue_op, issue_q1, issue_q2, issue_v1, issue_v2, issue_rob,
        input  alu_cdb_en, alu_cdb_rob, alu_cdb_val,
        input  lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val,
        output rs_full, ex_en, ex_op, ex_v1, ex_v2, ex_rob
    );
endinterface

// File: rtl/rs_station.sv
// Reservation station for ALU/branch/jump/lui/auipc micro-ops: buffers issued ops,
// wakes operands from the ALU and LSB CDBs, dispatches the lowest ready entry.
module rs_station #(
    parameter int                DEPTH     = 16,
    parameter int                IDX_W     = 4,
    parameter int                TAG_W     = 5,
    parameter int                DATA_W    = 32,
    parameter int                OP_W      = 6,
    parameter logic [DATA_W-1:0] READY_TAG = 32'hFFFF_FFFF
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear,
    rs_station_if.slave  bus
);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] q1;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] q2;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  rob;
    } payload_t;

    typedef struct packed {
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] v;
    } operand_t;

    typedef struct packed {
        logic              en;
        logic [TAG_W-1:0]  rob;
        logic [DATA_W-1:0] val;
    } cdb_t;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    payload_t          ent [DEPTH];
    operand_t          wake1 [DEPTH];
    operand_t          wake2 [DEPTH];
    operand_t          iss_o1;
    operand_t          iss_o2;
    cdb_t              alu_cdb;
    cdb_t              lsb_cdb;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [CNT_W-1:0]  busy_cnt;
    logic              issue_ok;

    logic              ex_en_q;
    logic [OP_W-1:0]   ex_op_q;
    logic [DATA_W-1:0] ex_v1_q;
    logic [DATA_W-1:0] ex_v2_q;
    logic [TAG_W-1:0]  ex_rob_q;

    assign alu_cdb = '{en: bus.alu_cdb_en, rob: bus.alu_cdb_rob, val: bus.alu_cdb_val};
    assign lsb_cdb = '{en: bus.lsb_cdb_en, rob: bus.lsb_cdb_rob, val: bus.lsb_cdb_val};

    // A status names a producer when it equals the zero-extended ROB number.
    function automatic logic tag_hit(logic [DATA_W-1:0] q, cdb_t c);
        return c.en && (q != READY_TAG) && (q == DATA_W'(c.rob));
    endfunction

    // ALU wins if both buses ever carry the same tag.
    function automatic operand_t resolve(operand_t cur, cdb_t a, cdb_t l);
        operand_t r;
        r = cur;
        if (tag_hit(cur.q, a)) begin
            r = '{q: READY_TAG, v: a.val};
        end else if (tag_hit(cur.q, l)) begin
            r = '{q: READY_TAG, v: l.val};
        end
        return r;
    endfunction

    // Descending scan so the lowest index is the last one written.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        busy_cnt   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && ent[i].q1 == READY_TAG && ent[i].q2 == READY_TAG) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            busy_cnt = busy_cnt + CNT_W'(busy[i]);
        end
    end

    always_comb begin
        iss_o1 = resolve('{q: bus.issue_q1, v: bus.issue_v1}, alu_cdb, lsb_cdb);
        iss_o2 = resolve('{q: bus.issue_q2, v: bus.issue_v2}, alu_cdb, lsb_cdb);
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = resolve('{q: ent[i].q1, v: ent[i].v1}, alu_cdb, lsb_cdb);
            wake2[i] = resolve('{q: ent[i].q2, v: ent[i].v2}, alu_cdb, lsb_cdb);
        end
    end

    assign issue_ok = bus.issue_en && free_found;

    // The issue target is never busy and the dispatch target always is, so they never collide.
    always_comb begin
        busy_nxt = busy;
        if (sel_found) busy_nxt[sel_idx] = 1'b0;
        if (issue_ok)  busy_nxt[free_idx] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy     <= '0;
            ex_en_q  <= 1'b0;
            ex_op_q  <= '0;
            ex_v1_q  <= '0;
            ex_v2_q  <= '0;
            ex_rob_q <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                busy    <= '0;
                ex_en_q <= 1'b0;
            end else begin
                busy    <= busy_nxt;
                ex_en_q <= sel_found;
                if (sel_found) begin
                    ex_op_q  <= ent[sel_idx].op;
                    ex_v1_q  <= ent[sel_idx].v1;
                    ex_v2_q  <= ent[sel_idx].v2;
                    ex_rob_q <= ent[sel_idx].rob;
                end
            end
        end
    end

    // NOTE: the payload array has no reset; busy alone qualifies every field, so resetting it would only cost flops.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_ok && free_idx == IDX_W'(i)) begin
                    ent[i] <= '{op: bus.issue_op, q1: iss_o1.q, v1: iss_o1.v,
                                q2: iss_o2.q, v2: iss_o2.v, rob: bus.issue_rob};
                end else if (busy[i]) begin
                    {ent[i].q1, ent[i].v1} <= wake1[i];
                    {ent[i].q2, ent[i].v2} <= wake2[i];
                end
            end
        end
    end

    assign bus.rs_full = (busy_cnt >= CNT_W'(DEPTH - 1));
    assign bus.ex_en   = ex_en_q;
    assign bus.ex_op   = ex_op_q;
    assign bus.ex_v1   = ex_v1_q;
    assign bus.ex_v2   = ex_v2_q;
    assign bus.ex_rob  = ex_rob_q;

    // The issue stage must honour rs_full; an issue with no free slot is dropped.
    a_no_overflow : assert property (@(posedge clk_in) disable iff (!rst_in)
        (rdy_in && !clear && bus.issue_en) |-> free_found);
endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a slot-list model.
module tb_rs_station;
    localparam logic [31:0] RDY = 32'hFFFF_FFFF;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;
    logic clear  = 1'b0;

    rs_station_if #(.TAG_W(5), .DATA_W(32), .OP_W(6)) bus ();

    rs_station dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit [31:0] q1, v1, q2, v2;
        bit [4:0]  rob;
    } ment_t;

    ment_t     m   [16];
    ment_t     pre [16];
    bit        e_en;
    bit [5:0]  e_op;
    bit [31:0] e_v1, e_v2;
    bit [4:0]  e_rob;

    function automatic int m_count();
        int c = 0;
        foreach (m[i]) if (m[i].busy) c++;
        return c;
    endfunction

    function automatic void m_resolve(inout bit [31:0] q, inout bit [31:0] v);
        if (bus.alu_cdb_en && q == {27'b0, bus.alu_cdb_rob}) begin
            v = bus.alu_cdb_val; q = RDY;
        end else if (bus.lsb_cdb_en && q == {27'b0, bus.lsb_cdb_rob}) begin
            v = bus.lsb_cdb_val; q = RDY;
        end
    endfunction

    function automatic void model_edge();
        int sel = -1;
        int fr  = -1;
        if (clear) begin
            foreach (m[i]) m[i].busy = 1'b0;
            e_en = 1'b0;
            return;
        end
        pre = m;
        foreach (pre[i]) begin
            if (sel < 0 && pre[i].busy && pre[i].q1 == RDY && pre[i].q2 == RDY) sel = i;
            if (fr < 0 && !pre[i].busy) fr = i;
        end
        foreach (m[i]) begin
            if (m[i].busy) begin
                m_resolve(m[i].q1, m[i].v1);
                m_resolve(m[i].q2, m[i].v2);
            end
        end
        if (bus.issue_en && fr >= 0) begin
            m[fr].busy = 1'b1;
            m[fr].op   = bus.issue_op;
            m[fr].q1   = bus.issue_q1;
            m[fr].v1   = bus.issue_v1;
            m[fr].q2   = bus.issue_q2;
            m[fr].v2   = bus.issue_v2;
            m[fr].rob  = bus.issue_rob;
            m_resolve(m[fr].q1, m[fr].v1);
            m_resolve(m[fr].q2, m[fr].v2);
        end
        if (sel >= 0) begin
            e_en  = 1'b1;
            e_op  = pre[sel].op;
            e_v1  = pre[sel].v1;
            e_v2  = pre[sel].v2;
            e_rob = pre[sel].rob;
            m[sel].busy = 1'b0;
        end else begin
            e_en = 1'b0;
        end
    endfunction

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            e_en = 1'b0; e_op = '0; e_v1 = '0; e_v2 = '0; e_rob = '0;
        end else if (rdy_in) begin
            model_edge();
        end
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            check("m_ex_en",   bus.ex_en,   e_en);
            check("m_ex_op",   bus.ex_op,   e_op);
            check("m_ex_v1",   bus.ex_v1,   e_v1);
            check("m_ex_v2",   bus.ex_v2,   e_v2);
            check("m_ex_rob",  bus.ex_rob,  e_rob);
            check("m_rs_full", bus.rs_full, m_count() >= 15);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.issue_en   = 1'b0; bus.issue_op = '0; bus.issue_rob = '0;
        bus.issue_q1   = RDY;  bus.issue_v1 = '0;
        bus.issue_q2   = RDY;  bus.issue_v2 = '0;
        bus.alu_cdb_en = 1'b0; bus.alu_cdb_rob = '0; bus.alu_cdb_val = '0;
        bus.lsb_cdb_en = 1'b0; bus.lsb_cdb_rob = '0; bus.lsb_cdb_val = '0;
        clear          = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] q1, input logic [31:0] v1,
                         input logic [31:0] q2, input logic [31:0] v2, input logic [4:0] rob);
        bus.issue_en = 1'b1; bus.issue_op = op; bus.issue_rob = rob;
        bus.issue_q1 = q1;   bus.issue_v1 = v1;
        bus.issue_q2 = q2;   bus.issue_v2 = v2;
    endtask

    task automatic alu(input logic [4:0] rob, input logic [31:0] val);
        bus.alu_cdb_en = 1'b1; bus.alu_cdb_rob = rob; bus.alu_cdb_val = val;
    endtask

    task automatic lsb(input logic [4:0] rob, input logic [31:0] val);
        bus.lsb_cdb_en = 1'b1; bus.lsb_cdb_rob = rob; bus.lsb_cdb_val = val;
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    initial begin
        idle();
        rdy_in = 1'b1;
        repeat (2) step();
        check("rst_ex_en",   bus.ex_en,   0);
        check("rst_ex_rob",  bus.ex_rob,  0);
        check("rst_rs_full", bus.rs_full, 0);
        rst_in = 1'b1;
        step();

        // Ready add dispatches exactly one cycle after issue.
        issue(6'd3, RDY, 32'd5, RDY, 32'd7, 5'd3);
        step(); idle();
        check("t1_not_yet", bus.ex_en, 0);
        step();
        check("t1_ex_en",  bus.ex_en,  1);
        check("t1_ex_op",  bus.ex_op,  3);
        check("t1_ex_v1",  bus.ex_v1,  5);
        check("t1_ex_v2",  bus.ex_v2,  7);
        check("t1_ex_rob", bus.ex_rob, 3);
        step();
        check("t1_pulse", bus.ex_en, 0);

        // ALU wakeup then LSB wakeup.
        issue(6'd4, 32'd9, 32'd0, RDY, 32'd2, 5'd5);
        step();
        issue(6'd4, RDY, 32'd1, 32'd10, 32'd0, 5'd6);
        step(); idle();
        check("t2_held", bus.ex_en, 0);
        alu(5'd9, 32'h100);
        step(); idle();
        check("t2_wake_no_disp", bus.ex_en, 0);
        lsb(5'd10, 32'h222);
        step(); idle();
        check("t2a_ex_en",  bus.ex_en,  1);
        check("t2a_ex_v1",  bus.ex_v1,  32'h100);
        check("t2a_ex_rob", bus.ex_rob, 5);
        step();
        check("t2b_ex_en",  bus.ex_en,  1);
        check("t2b_ex_v2",  bus.ex_v2,  32'h222);
        check("t2b_ex_rob", bus.ex_rob, 6);
        step();
        check("t2_idle", bus.ex_en, 0);

        // Issue-time bypass from the LSB CDB.
        issue(6'd2, RDY, 32'd1, 32'd4, 32'd0, 5'd7);
        lsb(5'd4, 32'hABCD);
        step(); idle();
        step();
        check("t3_ex_en",  bus.ex_en,  1);
        check("t3_ex_v2",  bus.ex_v2,  32'hABCD);
        check("t3_ex_rob", bus.ex_rob, 7);
        step();

        // Fill 15 entries on tag 1, then drain in index order.
        for (int k = 0; k < 15; k++) begin
            issue(6'd1, 32'd1, 32'd0, RDY, k, 5'(k));
            step();
            if (k == 13) check("t4_not_full_14", bus.rs_full, 0);
        end
        idle();
        check("t4_full_15", bus.rs_full, 1);
        alu(5'd1, 32'h55);
        step(); idle();
        check("t4_full_after_wake", bus.rs_full, 1);
        for (int k = 0; k < 15; k++) begin
            step();
            check("t4_ex_en",  bus.ex_en,  1);
            check("t4_ex_rob", bus.ex_rob, k);
            check("t4_ex_v1",  bus.ex_v1,  32'h55);
            if (k == 0) check("t4_full_drop", bus.rs_full, 0);
        end
        step();
        check("t4_drained", bus.ex_en, 0);

        // Flush with simultaneous issue and CDB.
        for (int k = 0; k < 8; k++) begin
            issue(6'd6, 32'd2, 32'd0, RDY, 32'd0, 5'(16 + k));
            step();
        end
        idle();
        issue(6'd6, RDY, 32'd1, RDY, 32'd1, 5'd20);
        alu(5'd2, 32'h33);
        clear = 1'b1;
        step(); idle();
        check("t5_clear_en",   bus.ex_en,   0);
        check("t5_clear_full", bus.rs_full, 0);
        repeat (3) begin
            step();
            check("t5_quiet", bus.ex_en, 0);
        end
        alu(5'd2, 32'h33);
        step(); idle();
        step();
        check("t5_no_ghost", bus.ex_en, 0);
        issue(6'd6, RDY, 32'h44, RDY, 32'd0, 5'd21);
        step(); idle();
        step();
        check("t5_fresh_en",  bus.ex_en,  1);
        check("t5_fresh_rob", bus.ex_rob, 21);
        check("t5_fresh_v1",  bus.ex_v1,  32'h44);

        // Stall with a ready entry.
        issue(6'd5, RDY, 32'h77, RDY, 32'd0, 5'd12);
        step(); idle();
        rdy_in = 1'b0;
        issue(6'd5, RDY, 32'h88, RDY, 32'd0, 5'd30);
        repeat (5) begin
            step();
            check("t6_stall_en",  bus.ex_en,  0);
            check("t6_stall_rob", bus.ex_rob, 21);
        end
        idle();
        rdy_in = 1'b1;
        step();
        check("t6_resume_en",  bus.ex_en,  1);
        check("t6_resume_rob", bus.ex_rob, 12);
        check("t6_resume_v1",  bus.ex_v1,  32'h77);
        step();
        check("t6_idle", bus.ex_en, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy_in = ($urandom_range(7) != 0);
            if (m_count() <= 14 && $urandom_range(1) == 1) begin
                issue(6'($urandom_range(63)),
                      ($urandom_range(1) == 1) ? RDY : 32'($urandom_range(7)), $urandom,
                      ($urandom_range(1) == 1) ? RDY : 32'($urandom_range(7)), $urandom,
                      5'($urandom_range(31)));
            end
            if ($urandom_range(1) == 1) alu(5'($urandom_range(7)), $urandom);
            if ($urandom_range(2) == 0) lsb(5'($urandom_range(7)), $urandom);
            clear = ($urandom_range(99) == 0);
            step();
        end

        // Asynchronous reset mid-cycle with a live dispatch on the outputs.
        idle();
        rdy_in = 1'b1;
        clear  = 1'b1;
        step(); idle();
        issue(6'd7, RDY, 32'h99, RDY, 32'h11, 5'd13);
        step(); idle();
        step();
        check("t7_pre_en",  bus.ex_en,  1);
        check("t7_pre_rob", bus.ex_rob, 13);
        #2 rst_in = 1'b0;
        #1;
        check("t7_rst_en",   bus.ex_en,   0);
        check("t7_rst_op",   bus.ex_op,   0);
        check("t7_rst_v1",   bus.ex_v1,   0);
        check("t7_rst_v2",   bus.ex_v2,   0);
        check("t7_rst_rob",  bus.ex_rob,  0);
        check("t7_rst_full", bus.rs_full, 0);
        step();
        rst_in = 1'b1;
        step();
        check("t7_post_en", bus.ex_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
